// File: rtl/checkbit_sequencer.sv
// Queues checkpoint words pushed over LA and shows each on io_out for at least HOLD_CYCLES cycles.
// Optional: define CHECKBIT_DEDUP_EN to silently drop a push equal to the last accepted word.
module checkbit_sequencer #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 64
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] la_data_in,
  input  logic             la_push_i,
  input  logic             la_clr_i,
  output logic [WIDTH-1:0] io_out,
  output logic [WIDTH-1:0] io_oeb,
  output logic             busy,
  output logic             full,
  output logic             overflow,
  output logic [31:0]      la_data_out
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [3:0]        DEPTH_C   = 4'(DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [3:0]       count;
  logic             push_q;
  logic             push_ev;
  logic             dup;
  logic             accept;
  logic             do_push;
  logic             do_pop;
  logic             drop;
  logic [WIDTH-1:0] head;
  logic [15:0]      io_word;

`ifdef CHECKBIT_DEDUP_EN
  logic [WIDTH-1:0] last_word;
  logic             last_valid;

  // Remembers the most recent word actually written into the FIFO.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      last_valid <= 1'b0;
      last_word  <= '0;
    end else if (do_push) begin
      last_valid <= 1'b1;
      last_word  <= la_data_in;
    end
  end

  assign dup = last_valid && (la_data_in == last_word);
`else
  assign dup = 1'b0;
`endif

  assign push_ev = la_push_i & ~push_q;
  assign accept  = push_ev & ~dup;
  // In HOLD the next word may only replace the current one once the counter expires.
  assign do_pop  = (count != 4'd0) && ((state == ST_IDLE) || (hold_cnt == '0));
  assign do_push = accept && ((count != DEPTH_C) || do_pop);
  assign drop    = accept && (count == DEPTH_C) && !do_pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && do_push) begin
      mem[wr_ptr] <= la_data_in;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      push_q   <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      push_q <= la_push_i;
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + 4'd1;
      end else if (do_pop && !do_push) begin
        count <= count - 4'd1;
      end
      // A drop on the same edge as a clear leaves the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (la_clr_i) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      io_out   <= '0;
      io_oeb   <= '1;
    end else if (do_pop) begin
      io_out   <= head;
      io_oeb   <= '0;
      hold_cnt <= HOLD_LOAD;
      state    <= ST_HOLD;
    end else if (state == ST_HOLD) begin
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  assign busy        = (state == ST_HOLD);
  assign full        = (count == DEPTH_C);
  assign io_word     = 16'(io_out);
  assign la_data_out = {9'd0, count, overflow, full, busy, io_word};

endmodule

// File: tb/tb_checkbit_sequencer.sv
// Testbench for checkbit_sequencer: directed vector table, corner-case sequences and a random run
// checked against an age-based behavioural model. Honours CHECKBIT_DEDUP_EN when defined.
module tb_checkbit_sequencer;

  localparam int HOLD  = 64;
  localparam int DEPTH = 4;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        push = 1'b0;
  logic        clr  = 1'b0;
  logic [15:0] data = 16'h0;
  logic [15:0] io_out;
  logic [15:0] io_oeb;
  logic        busy;
  logic        full;
  logic        overflow;
  logic [31:0] la_data_out;

  int tests    = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        push;
    logic        clr;
    logic [15:0] data;
    int          idle;
    logic [15:0] exp_io;
    logic [15:0] exp_oeb;
    logic        exp_busy;
    int          exp_count;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  // Model: FIFO as a queue, and the age of the displayed word in cycles.
  logic [15:0] m_q[$];
  logic [15:0] m_shown     = 16'h0;
  bit          m_oe        = 1'b0;
  int          m_age       = HOLD + 1;
  bit          m_ovf       = 1'b0;
  bit          m_push_q    = 1'b0;
  logic [15:0] m_last      = 16'h0;
  bit          m_have_last = 1'b0;

  checkbit_sequencer #(
    .WIDTH(16),
    .DEPTH(DEPTH),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .la_data_in(data),
    .la_push_i(push),
    .la_clr_i(clr),
    .io_out(io_out),
    .io_oeb(io_oeb),
    .busy(busy),
    .full(full),
    .overflow(overflow),
    .la_data_out(la_data_out)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit p, input bit c, input logic [15:0] d);
    bit ev;
    bit pop;
    bit dup;
    bit drop;
    if (r) begin
      m_q.delete();
      m_shown     = 16'h0;
      m_oe        = 1'b0;
      m_age       = HOLD + 1;
      m_ovf       = 1'b0;
      m_push_q    = 1'b0;
      m_have_last = 1'b0;
      m_last      = 16'h0;
      return;
    end
    ev       = p && !m_push_q;
    m_push_q = p;
    pop      = (m_q.size() > 0) && (m_age >= HOLD);
    dup      = 1'b0;
`ifdef CHECKBIT_DEDUP_EN
    dup = m_have_last && (d == m_last);
`endif
    drop = ev && !dup && (m_q.size() == DEPTH) && !pop;
    if (pop) begin
      m_shown = m_q.pop_front();
      m_oe    = 1'b1;
      m_age   = 1;
    end else if (m_age <= HOLD) begin
      m_age++;
    end
    if (ev && !dup && !drop) begin
      m_q.push_back(d);
      m_last      = d;
      m_have_last = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic checkOutput();
    logic [31:0] exp_status;
    logic        exp_busy;
    logic        exp_full;
    exp_busy   = (m_age <= HOLD);
    exp_full   = (m_q.size() == DEPTH);
    exp_status = {9'd0, 4'(m_q.size()), m_ovf, exp_full, exp_busy, m_shown};
    checkValue("model io_out", 32'(io_out), 32'(m_shown));
    checkValue("model io_oeb", 32'(io_oeb), m_oe ? 32'h0 : 32'hFFFF);
    checkValue("model busy", 32'(busy), 32'(exp_busy));
    checkValue("model full", 32'(full), 32'(exp_full));
    checkValue("model overflow", 32'(overflow), 32'(m_ovf));
    checkValue("model la_data_out", la_data_out, exp_status);
  endtask

  task automatic applyStimulus(input logic r, input logic p, input logic c, input logic [15:0] d);
    rst  = r;
    push = p;
    clr  = c;
    data = d;
    @(posedge clk);
    model_edge(r, p, c, d);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic add_vec(input logic r, input logic p, input logic c, input logic [15:0] d, input int idle,
                         input logic [15:0] eio, input logic [15:0] eoeb, input logic eb, input int ec,
                         input logic eovf);
    vec_t v;
    v.rst = r; v.push = p; v.clr = c; v.data = d; v.idle = idle;
    v.exp_io = eio; v.exp_oeb = eoeb; v.exp_busy = eb; v.exp_count = ec; v.exp_ovf = eovf;
    vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] seen[$];
    logic [31:0] exp_status;
    logic [15:0] rdata;
    int          cnt;
    bit          done;

    // rst push clr data idle | io_out oeb busy count ovf
    add_vec(1, 0, 0, 16'h0000, 20, 16'h0000, 16'hFFFF, 0, 0, 0);
    add_vec(0, 1, 0, 16'hAB40,  0, 16'h0000, 16'hFFFF, 0, 1, 0);
    add_vec(0, 0, 0, 16'h0000,  0, 16'hAB40, 16'h0000, 1, 0, 0);
    add_vec(0, 0, 0, 16'h0000, 62, 16'hAB40, 16'h0000, 1, 0, 0);
    add_vec(0, 0, 0, 16'h0000,  0, 16'hAB40, 16'h0000, 0, 0, 0);
    add_vec(0, 1, 0, 16'hAB41,  0, 16'hAB40, 16'h0000, 0, 1, 0);
    add_vec(0, 0, 0, 16'h0000,  0, 16'hAB41, 16'h0000, 1, 0, 0);
    add_vec(0, 1, 0, 16'hAB51,  0, 16'hAB41, 16'h0000, 1, 1, 0);
    add_vec(0, 0, 1, 16'h0000,  0, 16'hAB41, 16'h0000, 1, 1, 0);
    add_vec(0, 1, 0, 16'hAB40,  0, 16'hAB41, 16'h0000, 1, 2, 0);
    add_vec(0, 0, 0, 16'h0000,100, 16'hAB51, 16'h0000, 1, 1, 0);
    add_vec(0, 0, 0, 16'h0000,100, 16'hAB40, 16'h0000, 0, 0, 0);

    @(negedge clk);
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].push, vecs[k].clr, vecs[k].data);
      for (int j = 0; j < vecs[k].idle; j++) applyStimulus(0, 0, 0, 16'h0);
      exp_status = {9'd0, 4'(vecs[k].exp_count), vecs[k].exp_ovf, (vecs[k].exp_count == DEPTH),
                    vecs[k].exp_busy, vecs[k].exp_io};
      checkValue($sformatf("vec%0d io_out", k), 32'(io_out), 32'(vecs[k].exp_io));
      checkValue($sformatf("vec%0d io_oeb", k), 32'(io_oeb), 32'(vecs[k].exp_oeb));
      checkValue($sformatf("vec%0d busy", k), 32'(busy), 32'(vecs[k].exp_busy));
      checkValue($sformatf("vec%0d la_data_out", k), la_data_out, exp_status);
    end

    // Six pushes while the first word is held: fifth fills, sixth overflows.
    applyStimulus(1, 0, 0, 16'h0);
    applyStimulus(0, 1, 0, 16'h1000);
    applyStimulus(0, 0, 0, 16'h0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 1, 0, 16'h1000 + 16'(i));
      applyStimulus(0, 0, 0, 16'h0);
      if (i == 4) begin
        checkValue("ovf full after 5th push", 32'(full), 32'd1);
        checkValue("ovf flag before drop", 32'(overflow), 32'd0);
      end
    end
    checkValue("ovf flag after 6th push", 32'(overflow), 32'd1);
    checkValue("ovf count stays full", 32'(la_data_out[22:19]), 32'd4);
    applyStimulus(0, 0, 1, 16'h0);
    checkValue("ovf cleared", 32'(overflow), 32'd0);
    seen.delete();
    seen.push_back(16'h1000);
    done = 1'b0;
    for (int s = 0; s < 400 && !done; s++) begin
      applyStimulus(0, 0, 0, 16'h0);
      if (io_out != seen[$]) seen.push_back(io_out);
      if (!busy && la_data_out[22:19] == 4'd0) done = 1'b1;
    end
    checkValue("ovf drain finished", 32'(done), 32'd1);
    checkValue("ovf displayed count", 32'(seen.size()), 32'd5);
    for (int k = 0; k < 5 && k < seen.size(); k++)
      checkValue($sformatf("ovf order %0d", k), 32'(seen[k]), 32'(16'h1000 + 16'(k)));

    // Reset mid-HOLD with three words queued.
    applyStimulus(1, 0, 0, 16'h0);
    applyStimulus(0, 1, 0, 16'h2000);
    applyStimulus(0, 0, 0, 16'h0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1, 0, 16'h2000 + 16'(i));
      applyStimulus(0, 0, 0, 16'h0);
    end
    checkValue("rst pre count", 32'(la_data_out[22:19]), 32'd3);
    applyStimulus(1, 0, 0, 16'h0);
    checkValue("rst io_out", 32'(io_out), 32'h0);
    checkValue("rst io_oeb", 32'(io_oeb), 32'hFFFF);
    checkValue("rst count", 32'(la_data_out[22:19]), 32'd0);
    checkValue("rst busy", 32'(busy), 32'd0);
    applyStimulus(0, 1, 0, 16'h1234);
    applyStimulus(0, 0, 0, 16'h0);
    checkValue("post-rst io_out", 32'(io_out), 32'h1234);
    checkValue("post-rst io_oeb", 32'(io_oeb), 32'h0);

    // Consecutive duplicate pushes.
    applyStimulus(1, 0, 0, 16'h0);
    applyStimulus(0, 1, 0, 16'hAB41);
    applyStimulus(0, 0, 0, 16'h0);
    cnt = 0;
    applyStimulus(0, 1, 0, 16'hAB41); cnt++;
    applyStimulus(0, 0, 0, 16'h0);    cnt++;
    applyStimulus(0, 1, 0, 16'hAB51); cnt++;
`ifdef CHECKBIT_DEDUP_EN
    checkValue("dup queued count", 32'(la_data_out[22:19]), 32'd1);
`else
    checkValue("dup queued count", 32'(la_data_out[22:19]), 32'd2);
`endif
    while (io_out != 16'hAB51 && cnt < 300) begin
      applyStimulus(0, 0, 0, 16'h0);
      cnt++;
    end
`ifdef CHECKBIT_DEDUP_EN
    checkValue("dup AB41 display cycles", 32'(cnt), 32'd64);
`else
    checkValue("dup AB41 display cycles", 32'(cnt), 32'd128);
`endif
    checkValue("dup overflow", 32'(overflow), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 3))
        0: rdata = 16'hAB40;
        1: rdata = 16'hAB41;
        2: rdata = 16'hAB51;
        default: rdata = 16'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 1499) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 31) == 0), rdata);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/checkbit_sequencer.md
Name: checkbit_sequencer

Overview:
User-project block that drives 16-bit checkpoint words onto the checkbit pins (mprj_io[31:16] at top level) for the external observer, which watches those pins for words such as 16'hAB40, 16'hAB41 and 16'hAB51.
- Firmware pushes words through the logic analyzer.
- The block queues them in a small FIFO.
- It presents each word on the pins for a guaranteed minimum hold time, so a slow observer cannot miss back-to-back checkpoints.
- Status is read back over LA.

Parameters:
- WIDTH, 16, checkpoint word width.
- DEPTH, 4, FIFO entries; power of 2, legal range 2..8.
- HOLD_CYCLES, 64, minimum clock cycles each word stays on io_out before the next word may replace it; must be ≥1.

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_i  in  1  reset; synchronous, active-high.
- la_data_in  in  WIDTH  word to enqueue.
- la_push_i  in  1  push request; the rising edge is the event.
- la_clr_i  in  1  level; while high, clears the overflow flag.
- io_out  out  WIDTH  displayed word, mapped to mprj_io[31:16].
- io_oeb  out  WIDTH  pad output enable, active-low.
- busy  out  1  high while in HOLD.
- full  out  1  FIFO count == DEPTH.
- overflow  out  1  sticky; a push was dropped.
- la_data_out  out  32  status: [15:0]=io_out, [16]=busy, [17]=full, [18]=overflow, [22:19]=count, [31:23]=0.

Behaviour:
- Reset values (wb_rst_i sampled high at a rising edge):
  - io_out=0, io_oeb=all 1s, busy=0, full=0, overflow=0.
  - count=0, rd/wr pointers=0, push_q=0, state=IDLE, hold counter=0.
  - Reset asserted mid-HOLD or with the FIFO non-empty discards all queued words and returns to IDLE immediately; io_oeb returns to all 1s.
- Push detection:
  - push_q registers la_push_i.
  - A push event occurs at an edge where la_push_i=1 and push_q=0.
  - la_data_in is written to the FIFO at that same edge.
  - Holding la_push_i high produces exactly one push.
- FSM, 2 states:
  - IDLE: if count>0, pop the head at this edge, io_out<=head, io_oeb<=0, hold counter<=HOLD_CYCLES-1, go to HOLD. Otherwise remain in IDLE.
  - HOLD: busy=1. Decrement the counter each cycle. When the counter is 0 and count>0, pop the next word directly: io_out updates, counter reloads, stay in HOLD (no idle bubble). When the counter is 0 and count==0, go to IDLE; io_out keeps its last value.
  - Each word is therefore visible for exactly HOLD_CYCLES cycles when followed by another word, and indefinitely otherwise.
- io_oeb: once driven to 0 it stays 0 until reset.
- Latency: a push at edge N is displayed at edge N+1 if the block was IDLE with an empty FIFO.
- FIFO boundaries:
  - Push with count==DEPTH and no pop at the same edge: the word is dropped and overflow<=1; count is unchanged.
  - Push and pop at the same edge: both are performed and count is unchanged, including when full (no overflow).
  - Pointers wrap modulo DEPTH.
  - A pop never occurs while empty.
- Overflow: cleared on any edge where la_clr_i=1. If a drop and la_clr_i=1 coincide, the set wins.
- Ordering: strict FIFO; no word is reordered or duplicated.

Optional Feature:
- Macro CHECKBIT_DEDUP_EN.
- Defined: a push whose la_data_in equals the most recently accepted word (last word written to the FIFO since reset) is discarded silently. count, full and overflow are unaffected, and the last-accepted register is not updated. The first push after reset is always accepted.
- Undefined: every push is enqueued, including consecutive duplicates, each held for HOLD_CYCLES.

Test Plan:
- Reset, then idle 20 cycles -> io_out=0000, io_oeb=FFFF, la_data_out=0.
- Push AB40 with the block idle -> io_out=AB40 one edge after the push edge, io_oeb=0000, busy=1 for 64 cycles, then busy=0 and io_out holds AB40.
- Push AB40, AB41, AB51 on consecutive push pulses -> the pins show AB40, AB41, AB51, each exactly 64 cycles apart; count peaks at 2; final io_out=AB51.
- With HOLD_CYCLES=64 and DEPTH=4, push 6 words while the first word is held -> full=1 after the 5th push; the 6th push is dropped and overflow=1; the five accepted words display in order. Then pulse la_clr_i -> overflow=0.
- Assert wb_rst_i mid-HOLD with 3 words queued -> next cycle io_out=0000, io_oeb=FFFF, count=0, busy=0; a subsequent push of 1234 displays 1234.
- CHECKBIT_DEDUP_EN defined: push AB41, AB41, AB51 -> only AB41 and AB51 are displayed, overflow=0. Undefined: AB41 is displayed for 128 cycles in total before AB51.
